// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-PC source encodings
// and the fixed instruction size.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_JR  = 2'b10,
    PC_J   = 2'b11
  } pcsrc_e;

  localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. Pushing while full overwrites the oldest
// entry; a simultaneous push and pop replaces the top entry in place.
module pc_ras #(
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned WIDTH     = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    top_idx;
  logic [PW:0]      cnt;
  logic             pop_ok;

  // ptr is the next free slot; wrapping it is what discards the oldest entry
  assign top_idx = ptr - PW'(1);
  assign top     = mem[top_idx];
  assign empty   = (cnt == '0);
  assign full    = (cnt == (PW+1)'(RAS_DEPTH));
  assign pop_ok  = pop && !empty;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push && !pop_ok) begin
      ptr <= ptr + PW'(1);
      if (!full) cnt <= cnt + 1'b1;
    end else if (pop_ok && !push) begin
      ptr <= top_idx;
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[pop_ok ? top_idx : ptr] <= din;
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit with branch/jr/jump selection and sticky misalignment
// detection. Define PC_UNIT_RAS_EN to include the return-address stack.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int unsigned      RAS_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             PCWre,
  input  logic [1:0]       PCSrc,
  input  logic             BrTaken,
  input  logic [WIDTH-1:0] imm,
  input  logic [25:0]      jaddr,
  input  logic [WIDTH-1:0] rs_data,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] curPC,
  output logic [WIDTH-1:0] pc4,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             misalign
);

  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] j_target;
  logic [WIDTH-1:0] sel_pc;
  logic [WIDTH-1:0] nextPC;
  logic [WIDTH-1:0] ras_top;
  logic             use_ras;
  logic             mis_tgt;
  logic             upd;

  assign pc4       = curPC + WIDTH'(INSTR_BYTES);
  assign br_target = pc4 + (imm << 2);
  assign j_target  = {pc4[WIDTH-1:28], jaddr, 2'b00};

  always_comb begin
    sel_pc = pc4;
    case (pcsrc_e'(PCSrc))
      PC_SEQ:  sel_pc = pc4;
      PC_BR:   sel_pc = BrTaken ? br_target : pc4;
      PC_JR:   sel_pc = rs_data;
      PC_J:    sel_pc = j_target;
      default: sel_pc = pc4;
    endcase
  end

  assign nextPC  = use_ras ? ras_top : sel_pc;
  assign mis_tgt = |nextPC[1:0];
  assign upd     = PCWre && !mis_tgt;

`ifdef PC_UNIT_RAS_EN
  logic ras_push;
  logic ras_pop;

  // stack only moves on a committed update, so a misaligned target leaves it intact
  assign use_ras  = ret && !ras_empty;
  assign ras_push = call && upd;
  assign ras_pop  = use_ras && upd;

  pc_ras #(
    .RAS_DEPTH (RAS_DEPTH),
    .WIDTH     (WIDTH)
  ) u_ras (
    .CLK   (CLK),
    .Reset (Reset),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (pc4),
    .top   (ras_top),
    .empty (ras_empty),
    .full  (ras_full)
  );
`else
  localparam int unsigned ras_depth_unused = RAS_DEPTH;
  logic ras_unused;

  assign ras_unused = call ^ ret;
  assign use_ras    = 1'b0;
  assign ras_top    = '0;
  assign ras_empty  = 1'b1;
  assign ras_full   = 1'b0;
`endif

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      curPC    <= RESET_VEC;
      misalign <= 1'b0;
    end else begin
      if (upd) curPC <= nextPC;
      if (PCWre && mis_tgt) misalign <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit; expectations adapt to PC_UNIT_RAS_EN.
module tb_pc_unit;
  import pc_pkg::*;

  localparam int unsigned W  = 32;
  localparam logic [31:0] RV = 32'h0000_0000;
  localparam int unsigned D  = 4;
`ifdef PC_UNIT_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        PCWre = 1'b0;
  logic [1:0]  PCSrc = 2'b00;
  logic        BrTaken = 1'b0;
  logic [31:0] imm = '0;
  logic [25:0] jaddr = '0;
  logic [31:0] rs_data = '0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic [31:0] curPC, pc4;
  logic        ras_empty, ras_full, misalign;

  pc_unit #(.WIDTH(W), .RESET_VEC(RV), .RAS_DEPTH(D)) dut (
    .CLK(CLK), .Reset(Reset), .PCWre(PCWre), .PCSrc(PCSrc), .BrTaken(BrTaken),
    .imm(imm), .jaddr(jaddr), .rs_data(rs_data), .call(call), .ret(ret),
    .curPC(curPC), .pc4(pc4), .ras_empty(ras_empty), .ras_full(ras_full),
    .misalign(misalign)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] pc;
    logic        mis;
    logic        emp;
    logic        full;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] m_pc;
  logic        m_mis;
  logic [31:0] m_stk[$];

  task automatic model_reset();
    m_pc  = RV;
    m_mis = 1'b0;
    m_stk.delete();
  endtask

  function automatic exp_t model_exp();
    exp_t x;
    x.pc   = m_pc;
    x.mis  = m_mis;
    x.emp  = RAS_EN ? (m_stk.size() == 0) : 1'b1;
    x.full = RAS_EN ? (m_stk.size() == D) : 1'b0;
    return x;
  endfunction

  // Drives one cycle, advances the reference model, queues the expectation.
  task automatic drive(input logic we, input logic [1:0] src, input logic br,
                       input logic [31:0] im, input logic [25:0] ja,
                       input logic [31:0] rs, input logic c, input logic r);
    logic [31:0] p4, nxt;
    bit          use_top;
    PCWre = we; PCSrc = src; BrTaken = br; imm = im; jaddr = ja;
    rs_data = rs; call = c; ret = r;
    p4 = m_pc + 32'd4;
    case (src)
      2'd0:    nxt = p4;
      2'd1:    nxt = br ? p4 + (im << 2) : p4;
      2'd2:    nxt = rs;
      default: nxt = {p4[31:28], ja, 2'b00};
    endcase
    use_top = RAS_EN && r && (m_stk.size() != 0);
    if (use_top) nxt = m_stk[m_stk.size()-1];
    if (we) begin
      if (nxt[1:0] != 2'b00) m_mis = 1'b1;
      else begin
        if (RAS_EN && c) begin
          if (use_top) m_stk[m_stk.size()-1] = p4;
          else begin
            m_stk.push_back(p4);
            if (m_stk.size() > D) void'(m_stk.pop_front());
          end
        end else if (use_top) void'(m_stk.pop_back());
        m_pc = nxt;
      end
    end
    sb.push_back(model_exp());
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    model_reset();
    #3;
    tests++;
    if ({curPC, pc4, misalign, ras_empty, ras_full} !== {RV, RV + 32'd4, 1'b0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset: got pc=%h pc4=%h mis=%b emp=%b full=%b, want pc=%h mis=0 emp=1 full=0",
               curPC, pc4, misalign, ras_empty, ras_full, RV);
    end
    @(negedge CLK);
    Reset = 1'b1;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, PC_SEQ, 1'b0, '0, '0, '0, 1'b0, 1'b0);
      e = sb.pop_front();
      tests++;
      if ({curPC, pc4, misalign, ras_empty, ras_full} !== {e.pc, e.pc + 32'd4, e.mis, e.emp, e.full}
          || curPC !== 32'(4 * (i + 1))) begin
        fails++;
        $display("FAIL seq[%0d]: got pc=%h mis=%b emp=%b full=%b, want pc=%h mis=%b emp=%b full=%b",
                 i, curPC, misalign, ras_empty, ras_full, e.pc, e.mis, e.emp, e.full);
      end
    end
  endtask

  task automatic test_branch();
    logic [1:0]  src  [7] = '{PC_JR, PC_BR, PC_JR, PC_BR, PC_JR, PC_SEQ, PC_BR};
    logic        br   [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] rs   [7] = '{32'h100, 32'h0, 32'h100, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h0};
    logic [31:0] want [7] = '{32'h100, 32'h0FC, 32'h100, 32'h104, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC};
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, src[i], br[i], 32'hFFFF_FFFE, '0, rs[i], 1'b0, 1'b0);
      e = sb.pop_front();
      tests++;
      if ({curPC, pc4, misalign, ras_empty, ras_full} !== {e.pc, e.pc + 32'd4, e.mis, e.emp, e.full}
          || curPC !== want[i]) begin
        fails++;
        $display("FAIL branch[%0d]: got pc=%h pc4=%h mis=%b, want pc=%h (model %h) mis=%b",
                 i, curPC, pc4, misalign, want[i], e.pc, e.mis);
      end
    end
  endtask

  task automatic test_jump_misalign();
    logic [1:0]  src  [4] = '{PC_JR, PC_J, PC_JR, PC_SEQ};
    logic [31:0] rs   [4] = '{32'h1000_0000, 32'h0, 32'h202, 32'h0};
    logic [31:0] want [4] = '{32'h1000_0000, 32'h1000_0100, 32'h1000_0100, 32'h1000_0104};
    logic        wmis [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, src[i], 1'b0, '0, 26'h40, rs[i], 1'b0, 1'b0);
      e = sb.pop_front();
      tests++;
      if ({curPC, misalign, ras_empty, ras_full} !== {e.pc, e.mis, e.emp, e.full}
          || curPC !== want[i] || misalign !== wmis[i]) begin
        fails++;
        $display("FAIL jump[%0d]: got pc=%h mis=%b, want pc=%h mis=%b",
                 i, curPC, misalign, want[i], wmis[i]);
      end
    end
    Reset = 1'b0;
    model_reset();
    #2;
    tests++;
    if (misalign !== 1'b0 || curPC !== RV) begin
      fails++;
      $display("FAIL mis_clear: got pc=%h mis=%b, want pc=%h mis=0", curPC, misalign, RV);
    end
    Reset = 1'b1;
  endtask

  task automatic test_hold();
    drive(1'b1, PC_JR, 1'b0, '0, '0, 32'h200, 1'b1, 1'b0);
    e = sb.pop_front();
    tests++;
    if ({curPC, misalign, ras_empty, ras_full} !== {e.pc, e.mis, e.emp, e.full}) begin
      fails++;
      $display("FAIL hold_pre: got pc=%h emp=%b full=%b, want pc=%h emp=%b full=%b",
               curPC, ras_empty, ras_full, e.pc, e.emp, e.full);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, PC_J, 1'b0, '0, 26'h3FF, '0, 1'b1, 1'(i & 1));
      e = sb.pop_front();
      tests++;
      if ({curPC, misalign, ras_empty, ras_full} !== {e.pc, e.mis, e.emp, e.full}
          || curPC !== 32'h200) begin
        fails++;
        $display("FAIL hold[%0d]: got pc=%h emp=%b full=%b, want pc=%h emp=%b full=%b",
                 i, curPC, ras_empty, ras_full, e.pc, e.emp, e.full);
      end
    end
    // the entry pushed before the freeze must still come back as a return target
    drive(1'b1, PC_SEQ, 1'b0, '0, '0, '0, 1'b0, 1'b1);
    e = sb.pop_front();
    tests++;
    if ({curPC, misalign, ras_empty, ras_full} !== {e.pc, e.mis, e.emp, e.full}) begin
      fails++;
      $display("FAIL hold_ret: got pc=%h emp=%b, want pc=%h emp=%b", curPC, ras_empty, e.pc, e.emp);
    end
  endtask

  task automatic test_ras();
    logic [31:0] want_ret [4] = '{32'h54, 32'h44, 32'h34, 32'h24};
    Reset = 1'b0; model_reset(); #2; Reset = 1'b1;
    drive(1'b1, PC_JR, 1'b0, '0, '0, 32'h10, 1'b0, 1'b0);
    void'(sb.pop_front());
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, PC_JR, 1'b0, '0, '0, 32'(16 * (k + 1)), 1'b1, 1'b0);
      e = sb.pop_front();
      tests++;
      if ({curPC, misalign, ras_empty, ras_full} !== {e.pc, e.mis, e.emp, e.full}) begin
        fails++;
        $display("FAIL call[%0d]: got pc=%h emp=%b full=%b, want pc=%h emp=%b full=%b",
                 k, curPC, ras_empty, ras_full, e.pc, e.emp, e.full);
      end
    end
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, PC_SEQ, 1'b0, '0, '0, '0, 1'b0, 1'b1);
      e = sb.pop_front();
      tests++;
      if ({curPC, misalign, ras_empty, ras_full} !== {e.pc, e.mis, e.emp, e.full}
          || (RAS_EN && k < 4 && curPC !== want_ret[k])) begin
        fails++;
        $display("FAIL ret[%0d]: got pc=%h emp=%b full=%b, want pc=%h emp=%b full=%b",
                 k, curPC, ras_empty, ras_full, e.pc, e.emp, e.full);
      end
    end
    // call+ret together: target is old top, top becomes pc4, depth unchanged
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, PC_JR, 1'b0, '0, '0, 32'h400 + 32'(k * 32'h40), 1'(k != 3), 1'(k >= 2));
      e = sb.pop_front();
      tests++;
      if ({curPC, misalign, ras_empty, ras_full} !== {e.pc, e.mis, e.emp, e.full}) begin
        fails++;
        $display("FAIL callret[%0d]: got pc=%h emp=%b full=%b, want pc=%h emp=%b full=%b",
                 k, curPC, ras_empty, ras_full, e.pc, e.emp, e.full);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, PC_JR, 1'b0, '0, '0, 32'h800 + 32'(k * 32'h10), 1'b1, 1'b0);
      void'(sb.pop_front());
    end
    PCWre = 1'b1; PCSrc = PC_J; jaddr = 26'h123; call = 1'b1;
    #2;
    Reset = 1'b0;
    model_reset();
    #1;
    tests++;
    if (curPC !== RV || ras_empty !== 1'b1 || ras_full !== 1'b0 || misalign !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got pc=%h emp=%b full=%b mis=%b, want pc=%h emp=1 full=0 mis=0",
               curPC, ras_empty, ras_full, misalign, RV);
    end
    #2;
    Reset = 1'b1;
    drive(1'b1, PC_SEQ, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    e = sb.pop_front();
    tests++;
    if ({curPC, misalign, ras_empty, ras_full} !== {e.pc, e.mis, e.emp, e.full}
        || curPC !== RV + 32'd4) begin
      fails++;
      $display("FAIL post_reset: got pc=%h emp=%b, want pc=%h emp=%b", curPC, ras_empty, e.pc, e.emp);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rs;
    for (int i = 0; i < 300; i++) begin
      rs = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 63) == 0) rs = rs | 32'h2;
      drive(1'($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            32'($signed($urandom_range(0, 255)) - 128), 26'($urandom), rs,
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0));
      e = sb.pop_front();
      tests++;
      if ({curPC, pc4, misalign, ras_empty, ras_full} !== {e.pc, e.pc + 32'd4, e.mis, e.emp, e.full}) begin
        fails++;
        $display("FAIL rand[%0d]: got pc=%h mis=%b emp=%b full=%b, want pc=%h mis=%b emp=%b full=%b",
                 i, curPC, misalign, ras_empty, ras_full, e.pc, e.mis, e.emp, e.full);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump_misalign();
    test_hold();
    test_ras();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, default 32, PC and data width in bits (minimum 30).
REQ-002 Parameter RESET_VEC, default 32'h0000_0000, value loaded into curPC on reset.
REQ-003 Parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, 2..16).
REQ-004 CLK  in  1  single clock; all state updates on rising edge.
REQ-005 Reset  in  1  asynchronous, active-low reset.
REQ-006 PCWre  in  1  PC write enable; 0 freezes all state.
REQ-007 PCSrc  in  2  next-PC select: 00 sequential, 01 branch, 10 register (jr), 11 jump.
REQ-008 BrTaken  in  1  branch condition; used only when PCSrc=01.
REQ-009 imm  in  WIDTH  sign-extended word offset for branch.
REQ-010 jaddr  in  26  jump target word index.
REQ-011 rs_data  in  WIDTH  register jump target.
REQ-012 call  in  1  push return address (RAS).
REQ-013 ret  in  1  use and pop RAS top as target.
REQ-014 curPC  out  WIDTH  current instruction address.
REQ-015 pc4  out  WIDTH  curPC+4, combinational.
REQ-016 ras_empty / ras_full  out  1 each  RAS occupancy flags.
REQ-017 misalign  out  1  sticky misaligned-target error.

Function
REQ-018 nextPC SHALL be: 00 -> pc4; 01 -> BrTaken ? pc4+(imm<<2) : pc4; 10 -> rs_data; 11 -> {pc4[WIDTH-1:28], jaddr, 2'b00}.
REQ-019 All additions SHALL wrap modulo 2^WIDTH; no overflow flag.
REQ-020 On rising CLK with PCWre=1 and nextPC[1:0]=00, curPC SHALL take nextPC (one-cycle latency).
REQ-021 With PCWre=0, curPC, RAS contents, pointers and misalign SHALL hold; call/ret ignored.
REQ-022 With PCWre=1 and nextPC[1:0]!=00, curPC SHALL hold, misalign SHALL set and remain 1 until reset; RAS not modified that cycle.
REQ-023 ret=1 with RAS non-empty SHALL override PCSrc: nextPC = RAS top; entry popped on the update edge.
REQ-024 ret=1 with RAS empty SHALL use PCSrc selection; no pop; no error.
REQ-025 call=1 SHALL push pc4 on the update edge.
REQ-026 Push when full SHALL overwrite the oldest entry (circular); count saturates at RAS_DEPTH; ras_full stays 1.
REQ-027 call=1 and ret=1 together SHALL replace top with pc4 (target = old top); count unchanged.
REQ-028 ras_empty = (count==0), ras_full = (count==RAS_DEPTH), both registered-state derived.

Reset
REQ-029 Reset=0 SHALL immediately, independent of CLK, force curPC=RESET_VEC, RAS count=0, pointer=0, misalign=0.
REQ-030 Reset asserted mid-operation SHALL discard any pending update; first update after release uses curPC=RESET_VEC.
REQ-031 RAS entry storage need not be reset; only pointer/count are.

Configuration
REQ-032 Macro PC_UNIT_RAS_EN defined: RAS present per REQ-023..028.
REQ-033 Macro undefined: no RAS storage; call/ret ignored; ras_empty tied 1, ras_full tied 0; all other behaviour identical.

Structure
REQ-034 Package pc_pkg SHALL hold PCSrc encodings (PC_SEQ, PC_BR, PC_JR, PC_J) and the instruction-width constant 4.
REQ-035 RAS SHALL be sub-module pc_ras (push, pop, top, empty, full; parameter RAS_DEPTH, WIDTH), instantiated only under PC_UNIT_RAS_EN.

Verification
REQ-036 Reset=0 then release, PCWre=1, PCSrc=00 for 3 edges -> curPC 0, 4, 8, 12.
REQ-037 curPC=0x100, PCSrc=01, BrTaken=1, imm=-2 -> curPC=0x0FC; BrTaken=0 -> 0x104.
REQ-038 curPC=0x1000_0000, PCSrc=11, jaddr=0x40 -> curPC=0x1000_0100; PCSrc=10, rs_data=0x202 -> curPC holds, misalign=1 until reset.
REQ-039 PCWre=0 for 5 edges with PCSrc=11, call=1 -> curPC, RAS count unchanged.
REQ-040 RAS: 5 calls at PCs 0x10,0x20,0x30,0x40,0x50 (depth 4) -> ras_full=1; 4 rets -> targets 0x54,0x44,0x34,0x24, then ras_empty=1; 5th ret follows PCSrc=00.
REQ-041 Reset pulsed asynchronously between edges during call sequence -> curPC=RESET_VEC, ras_empty=1 immediately.
